username_entry_responder: RTL and testbench

//  View-side responder to the pregame name request (user_name_req: 00 none, 10 player 1, 11 player 2).
//  - Blanks the selected player's name slot.
//  - Collects ASCII keystrokes into that slot; letters are upper-cased.
//  - Supports backspace; Enter commits the name.
//  - Returns cbk_for_view to the pregame controller once the name is committed.
//  - Writes through a simple write port into the model's name storage.

---
 rtl/username_entry_responder.sv | 159 +++++++++++++++
 tb/tb_username_entry_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/username_entry_responder.sv
// Username entry responder: answers the pregame name request by blanking the
// selected player's name slot, then collecting keystrokes (upper-cased) into
// it with backspace support, and raising cbk_for_view once Enter commits.
//
// Handshake: there is no valid/ready pair here. key_valid is a one-cycle
// strobe that is always consumed (acted on or dropped); name_wr_en is a
// one-cycle write strobe that the name storage must accept unconditionally.
module username_entry_responder #(
   parameter int MAX_LEN = 8,
   parameter int ADDR_W  = 3,
   parameter int LEN_W   = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [1:0]        user_name_req,
   input  logic              key_valid,
   input  logic [7:0]        key_code,
   output logic              name_wr_en,
   output logic              name_wr_sel,
   output logic [ADDR_W-1:0] name_wr_addr,
   output logic [7:0]        name_wr_data,
   output logic [LEN_W-1:0]  name_len,
   output logic              editing,
   output logic              cbk_for_view,
   output logic [1:0]        o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_EDIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_LEN);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_LEN - 1);
   localparam logic [7:0]        C_SPACE   = 8'h20;
   localparam logic [7:0]        C_BKSP    = 8'h08;
   localparam logic [7:0]        C_ENTER   = 8'h0D;

   state_t              r_state, w_state_nxt;
   logic                r_sel, w_sel_nxt;
   logic [ADDR_W-1:0]   r_clr_cnt, w_clr_cnt_nxt;
   logic [LEN_W-1:0]    r_len, w_len_nxt;
   logic                r_wr_en, w_wr_en_nxt;
   logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
   logic [7:0]          r_wr_data, w_wr_data_nxt;
   logic                r_editing, r_cbk;

   logic                w_abort;
   logic [7:0]          w_code_uc;
   logic                w_printable;
   logic [LEN_W-1:0]    w_len_dec;

   // A dropped request or a player switch while still active both cancel entry
   assign w_abort     = !user_name_req[1] || (user_name_req[0] != r_sel);
   assign w_code_uc   = (key_code >= 8'h61 && key_code <= 8'h7A) ? (key_code - C_SPACE) : key_code;
   assign w_printable = (w_code_uc >= 8'h20) && (w_code_uc <= 8'h7E);
   assign w_len_dec   = r_len - 1'b1;

   // State register plus all registered outputs and datapath state
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_sel     <= 1'b0;
         r_clr_cnt <= '0;
         r_len     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_editing <= 1'b0;
         r_cbk     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sel     <= w_sel_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
         r_len     <= w_len_nxt;
         r_wr_en   <= w_wr_en_nxt;
         r_wr_addr <= w_wr_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_editing <= (w_state_nxt == S_EDIT);
         r_cbk     <= (w_state_nxt == S_DONE);
      end
   end

   // Next-state selection; abort beats any key arriving in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (user_name_req[1]) w_state_nxt = S_CLEAR;
         S_CLEAR: begin
            if (w_abort)                       w_state_nxt = S_IDLE;
            else if (r_clr_cnt == ADDR_LAST)   w_state_nxt = S_EDIT;
         end
         S_EDIT: begin
            if (w_abort)                       w_state_nxt = S_IDLE;
            else if (key_valid && key_code == C_ENTER && r_len != '0)
                                               w_state_nxt = S_DONE;
         end
         S_DONE:  if (user_name_req != {1'b1, r_sel}) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the write port, length counter and clear counter
   always_comb begin
      w_sel_nxt     = r_sel;
      w_clr_cnt_nxt = r_clr_cnt;
      w_len_nxt     = r_len;
      w_wr_en_nxt   = 1'b0;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      case (r_state)
         S_IDLE: begin
            if (user_name_req[1]) begin
               w_sel_nxt     = user_name_req[0];
               w_len_nxt     = '0;
               w_clr_cnt_nxt = '0;
            end
         end
         S_CLEAR: begin
            if (!w_abort) begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = r_clr_cnt;
               w_wr_data_nxt = C_SPACE;
               w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
         end
         S_EDIT: begin
            if (!w_abort && key_valid) begin
               if (w_printable) begin
                  if (r_len < LEN_MAX) begin
                     w_wr_en_nxt   = 1'b1;
                     w_wr_addr_nxt = r_len[ADDR_W-1:0];
                     w_wr_data_nxt = w_code_uc;
                     w_len_nxt     = r_len + 1'b1;
                  end
               end else if (key_code == C_BKSP && r_len != '0) begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_addr_nxt = w_len_dec[ADDR_W-1:0];
                  w_wr_data_nxt = C_SPACE;
                  w_len_nxt     = w_len_dec;
               end
            end
         end
         default: ;
      endcase
   end

   assign name_wr_en   = r_wr_en;
   assign name_wr_sel  = r_sel;
   assign name_wr_addr = r_wr_addr;
   assign name_wr_data = r_wr_data;
   assign name_len     = r_len;
   assign editing      = r_editing;
   assign cbk_for_view = r_cbk;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_username_entry_responder.sv
// Directed bench for username_entry_responder: write traffic is checked
// against an expected queue, status outputs against hand-computed values.
module tb_username_entry_responder;

   logic       clock;
   logic       resetn;
   logic [1:0] user_name_req;
   logic       key_valid;
   logic [7:0] key_code;
   logic       name_wr_en;
   logic       name_wr_sel;
   logic [2:0] name_wr_addr;
   logic [7:0] name_wr_data;
   logic [3:0] name_len;
   logic       editing;
   logic       cbk_for_view;
   logic [1:0] o_dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [11:0] exp_q[$];

   username_entry_responder dut (
      .clock         (clock),
      .resetn        (resetn),
      .user_name_req (user_name_req),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .name_wr_en    (name_wr_en),
      .name_wr_sel   (name_wr_sel),
      .name_wr_addr  (name_wr_addr),
      .name_wr_data  (name_wr_data),
      .name_len      (name_len),
      .editing       (editing),
      .cbk_for_view  (cbk_for_view),
      .o_dbg_state   (o_dbg_state)
   );

   // Clock and watchdog
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // Driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_wr(input logic sel, input logic [2:0] addr, input logic [7:0] data);
      exp_q.push_back({sel, addr, data});
   endtask

   task automatic press(input logic [7:0] code);
      key_valid = 1'b1;
      key_code  = code;
      tick();
      key_valid = 1'b0;
      key_code  = 8'h00;
   endtask

   task automatic start_clear(input logic sel);
      user_name_req = {1'b1, sel};
      tick();
      for (int i = 0; i < 8; i++) begin
         push_wr(sel, 3'(i), 8'h20);
         tick();
      end
      check_val("clear_editing", {31'd0, editing}, 32'd1);
      check_val("clear_len", {28'd0, name_len}, 32'd0);
   endtask

   // Scoreboard: every write strobe must match the head of the expected queue
   always @(negedge clock) begin
      if (resetn && name_wr_en) begin
         if (exp_q.size() == 0)
            check_val("wr_unexpected", {20'd0, name_wr_sel, name_wr_addr, name_wr_data}, 32'hFFFF_FFFF);
         else
            check_val("wr", {20'd0, name_wr_sel, name_wr_addr, name_wr_data}, {20'd0, exp_q.pop_front()});
      end
   end

   initial begin
      string s;
      resetn        = 1'b0;
      user_name_req = 2'b00;
      key_valid     = 1'b0;
      key_code      = 8'h00;
      tick();
      tick();
      resetn = 1'b1;
      tick();

      // Reset state
      check_val("rst_state", {30'd0, o_dbg_state}, 32'd0);
      check_val("rst_outs", {17'd0, name_wr_en, name_wr_sel, name_wr_addr, name_wr_data, name_len, editing, cbk_for_view}, 32'd0);

      // Async reset in the middle of a clear sequence
      user_name_req = 2'b10;
      tick();
      push_wr(1'b0, 3'd0, 8'h20);
      tick();
      push_wr(1'b0, 3'd1, 8'h20);
      tick();
      #5;
      resetn = 1'b0;
      #1;
      check_val("arst_outs", {17'd0, name_wr_en, name_wr_sel, name_wr_addr, name_wr_data, name_len, editing, cbk_for_view}, 32'd0);
      check_val("arst_state", {30'd0, o_dbg_state}, 32'd0);
      user_name_req = 2'b00;
      #1;
      resetn = 1'b1;
      tick();
      tick();
      tick();
      check_val("post_rst_state", {30'd0, o_dbg_state}, 32'd0);
      check_val("post_rst_wr_en", {31'd0, name_wr_en}, 32'd0);

      // Clear then type lowercase letters, commit, release
      start_clear(1'b0);
      push_wr(1'b0, 3'd0, 8'h41);
      press(8'h61);
      push_wr(1'b0, 3'd1, 8'h42);
      press(8'h62);
      check_val("ab_len", {28'd0, name_len}, 32'd2);
      press(8'h0D);
      check_val("ab_cbk", {31'd0, cbk_for_view}, 32'd1);
      check_val("ab_editing", {31'd0, editing}, 32'd0);
      check_val("ab_len_held", {28'd0, name_len}, 32'd2);
      user_name_req = 2'b00;
      #1;
      check_val("cbk_before_edge", {31'd0, cbk_for_view}, 32'd1);
      tick();
      check_val("cbk_drop", {31'd0, cbk_for_view}, 32'd0);
      check_val("idle_after_done", {30'd0, o_dbg_state}, 32'd0);

      // Overflow: nine letters, only eight stored
      start_clear(1'b0);
      s = "ABCDEFGHI";
      for (int i = 0; i < 9; i++) begin
         if (i < 8) push_wr(1'b0, 3'(i), s[i]);
         press(s[i]);
      end
      check_val("ovf_len", {28'd0, name_len}, 32'd8);
      check_val("ovf_q_empty", exp_q.size(), 32'd0);
      press(8'h0D);
      check_val("ovf_cbk", {31'd0, cbk_for_view}, 32'd1);
      user_name_req = 2'b00;
      tick();

      // Backspace and empty-Enter handling
      start_clear(1'b0);
      press(8'h08);
      check_val("bs0_len", {28'd0, name_len}, 32'd0);
      check_val("bs0_wr_en", {31'd0, name_wr_en}, 32'd0);
      push_wr(1'b0, 3'd0, 8'h58);
      press(8'h58);
      push_wr(1'b0, 3'd1, 8'h59);
      press(8'h79);
      push_wr(1'b0, 3'd1, 8'h20);
      press(8'h08);
      check_val("bs_len", {28'd0, name_len}, 32'd1);
      push_wr(1'b0, 3'd0, 8'h20);
      press(8'h08);
      press(8'h0D);
      check_val("enter0_cbk", {31'd0, cbk_for_view}, 32'd0);
      check_val("enter0_editing", {31'd0, editing}, 32'd1);
      press(8'h07);
      check_val("other_code_len", {28'd0, name_len}, 32'd0);
      push_wr(1'b0, 3'd0, 8'h4D);
      press(8'h4D);
      press(8'h0D);
      check_val("m_cbk", {31'd0, cbk_for_view}, 32'd1);

      // Direct handover from player 1 to player 2
      user_name_req = 2'b11;
      tick();
      check_val("ho_cbk", {31'd0, cbk_for_view}, 32'd0);
      check_val("ho_idle", {30'd0, o_dbg_state}, 32'd0);
      tick();
      check_val("ho_len", {28'd0, name_len}, 32'd0);
      check_val("ho_sel", {31'd0, name_wr_sel}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         push_wr(1'b1, 3'(i), 8'h20);
         tick();
      end
      check_val("ho_editing", {31'd0, editing}, 32'd1);

      // Abort wins over a simultaneous key
      push_wr(1'b1, 3'd0, 8'h51);
      press(8'h71);
      user_name_req = 2'b00;
      press(8'h5A);
      check_val("abort_wr_en", {31'd0, name_wr_en}, 32'd0);
      check_val("abort_state", {30'd0, o_dbg_state}, 32'd0);
      check_val("abort_cbk", {31'd0, cbk_for_view}, 32'd0);
      tick();
      tick();
      check_val("abort_cbk_late", {31'd0, cbk_for_view}, 32'd0);
      check_val("abort_editing", {31'd0, editing}, 32'd0);

      check_val("final_q_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
